// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI receive path.
//   - MIDI status byte constants used by the parser.
//   - midi_len(): number of data bytes that follow a status byte (0-2).
//   - uart_state_t: state encoding of the serial receiver.
package midi_pkg;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] ST_TUNE  = 8'hF6;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  // Data length for a status byte. A zero result covers three cases: the
  // status has no data bytes (F6), it is ignored (F4/F5), or it ends or opens
  // SysEx (F7/F0). The parser keeps a status as running status only when the
  // result is non-zero.
  function automatic logic [1:0] midi_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver for the MIDI line.
// Ports:
//   clk_sys      in   system clock
//   reset        in   synchronous active-high reset
//   rx           in   asynchronous serial input, idles high
//   byte_data    out  last correctly framed byte
//   byte_valid   out  one-cycle strobe, byte_data updated
//   framing_err  out  one-cycle strobe, stop bit sampled low (byte dropped)
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 31250
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  // Half a bit lands the START check in the middle of the start bit; every
  // later sample then falls a full bit period further on, mid-bit.
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        framing_err_q, framing_err_d;
  logic        cnt_done;

  assign cnt_done = (cnt_q == '0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    framing_err_d = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = UART_START;
          cnt_d   = HALF_LOAD;
        end
      end
      UART_START: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_sync_q) begin
          state_d   = UART_DATA;
          cnt_d     = FULL_LOAD;
          bit_idx_d = 3'd0;
        end else begin
          state_d = UART_IDLE; // line went high again: glitch, not a start bit
        end
      end
      UART_DATA: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d   = {rx_sync_q, shift_q[7:1]}; // LSB arrives first
          cnt_d     = FULL_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = UART_STOP;
        end
      end
      UART_STOP: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = UART_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            framing_err_d = 1'b1;
          end
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // NOTE: clocked blocks use non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      state_q       <= UART_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      byte_data_q   <= 8'h00;
      byte_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      rx_prev_q     <= rx_sync_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      framing_err_q <= framing_err_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign framing_err = framing_err_q;

endmodule

// File: rtl/midi_rx_parser.sv
// Passive MIDI monitor: deserialises the line and assembles channel and
// system-common messages with running status, splits out realtime bytes,
// tracks SysEx and stretches an activity pulse for the LED.
// Ports:
//   clk_sys, reset          clock, synchronous active-high reset
//   rx                      serial input (observed only)
//   byte_data/byte_valid    raw received byte and strobe
//   framing_err             strobe, stop bit low
//   msg_status/msg_d1/msg_d2/msg_valid   assembled message and strobe
//   rt_data/rt_valid        realtime byte and strobe
//   sysex_active            inside a SysEx block
//   orphan_cnt              saturating count of data bytes with no status
//   activity                high for ACT_CYCLES after any received byte
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 31250,
  parameter int ACT_CYCLES = 2500000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err,
  output logic [7:0] msg_status,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2,
  output logic       msg_valid,
  output logic [7:0] rt_data,
  output logic       rt_valid,
  output logic       sysex_active,
  output logic [7:0] orphan_cnt,
  output logic       activity
);

  localparam int AW = $clog2(ACT_CYCLES + 1);

  midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_uart (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .rx          (rx),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .framing_err (framing_err)
  );

  // run_status_q == 0 means no pending status (valid status bytes have bit 7).
  logic [7:0] run_status_q, run_status_d;
  logic       idx_q, idx_d;
  logic [6:0] pend_d1_q, pend_d1_d;
  logic       sysex_q, sysex_d;
  logic [7:0] orphan_q, orphan_d;
  logic [7:0] msg_status_q, msg_status_d;
  logic [6:0] msg_d1_q, msg_d1_d, msg_d2_q, msg_d2_d;
  logic       msg_valid_q, msg_valid_d;
  logic [7:0] rt_data_q, rt_data_d;
  logic       rt_valid_q, rt_valid_d;
  logic [AW-1:0] act_q, act_d;

  always_comb begin
    run_status_d = run_status_q;
    idx_d        = idx_q;
    pend_d1_d    = pend_d1_q;
    sysex_d      = sysex_q;
    orphan_d     = orphan_q;
    msg_status_d = msg_status_q;
    msg_d1_d     = msg_d1_q;
    msg_d2_d     = msg_d2_q;
    msg_valid_d  = 1'b0;
    rt_data_d    = rt_data_q;
    rt_valid_d   = 1'b0;

    if (byte_valid) begin
      if (byte_data >= RT_MIN) begin
        // Realtime bytes may interleave anywhere and leave parse state alone.
        rt_valid_d = 1'b1;
        rt_data_d  = byte_data;
      end else if (byte_data[7]) begin
        idx_d        = 1'b0;
        sysex_d      = (byte_data == ST_SYSEX);
        run_status_d = (midi_len(byte_data) != 2'd0) ? byte_data : 8'h00;
        if (byte_data == ST_TUNE) begin
          msg_valid_d  = 1'b1;
          msg_status_d = byte_data;
          msg_d1_d     = 7'h00;
          msg_d2_d     = 7'h00;
        end
      end else if (sysex_q) begin
        // SysEx payload is not assembled.
      end else if (run_status_q == 8'h00) begin
        if (orphan_q != 8'hFF) orphan_d = orphan_q + 8'd1;
      end else if (!idx_q && midi_len(run_status_q) == 2'd2) begin
        pend_d1_d = byte_data[6:0];
        idx_d     = 1'b1;
      end else begin
        msg_valid_d  = 1'b1;
        msg_status_d = run_status_q;
        msg_d1_d     = idx_q ? pend_d1_q : byte_data[6:0];
        msg_d2_d     = idx_q ? byte_data[6:0] : 7'h00;
        idx_d        = 1'b0;
        // System common does not run; channel messages keep their status.
        if (run_status_q[7:4] == 4'hF) run_status_d = 8'h00;
      end
    end

    act_d = act_q;
    if (byte_valid)        act_d = AW'(ACT_CYCLES - 1);
    else if (act_q != '0)  act_d = act_q - AW'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      run_status_q <= 8'h00;
      idx_q        <= 1'b0;
      pend_d1_q    <= 7'h00;
      sysex_q      <= 1'b0;
      orphan_q     <= 8'h00;
      msg_status_q <= 8'h00;
      msg_d1_q     <= 7'h00;
      msg_d2_q     <= 7'h00;
      msg_valid_q  <= 1'b0;
      rt_data_q    <= 8'h00;
      rt_valid_q   <= 1'b0;
      act_q        <= '0;
    end else begin
      run_status_q <= run_status_d;
      idx_q        <= idx_d;
      pend_d1_q    <= pend_d1_d;
      sysex_q      <= sysex_d;
      orphan_q     <= orphan_d;
      msg_status_q <= msg_status_d;
      msg_d1_q     <= msg_d1_d;
      msg_d2_q     <= msg_d2_d;
      msg_valid_q  <= msg_valid_d;
      rt_data_q    <= rt_data_d;
      rt_valid_q   <= rt_valid_d;
      act_q        <= act_d;
    end
  end

  assign msg_status   = msg_status_q;
  assign msg_d1       = msg_d1_q;
  assign msg_d2       = msg_d2_q;
  assign msg_valid    = msg_valid_q;
  assign rt_data      = rt_data_q;
  assign rt_valid     = rt_valid_q;
  assign sysex_active = sysex_q;
  assign orphan_cnt   = orphan_q;
  assign activity     = (act_q != '0);

endmodule

// File: doc/midi_rx_parser.md
Name: midi_rx_parser

Overview:
- Consumes the MIDI serial stream that the user-port mux routes to UART_TXD. The stream comes from the MT32-pi side (midi_rx) or the HPS UART.
- Deserialises 31250-baud 8N1 bytes and assembles complete MIDI channel and system-common messages, tracking running status.
- Separates out realtime bytes and flags SysEx activity.
- Feeds the menu core's MIDI activity LED and status/diagnostic registers. It observes the line only and never drives it.

Parameters:
- CLK_HZ, 50000000, clk_sys frequency in Hz.
- BAUD, 31250, serial bit rate.
- ACT_CYCLES, 2500000, activity-pulse stretch length in clk_sys cycles (50 ms at default).

Ports:
- clk_sys  in  1  system clock; every register is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- byte_data  out  8  last received byte.
- byte_valid  out  1  one-cycle strobe; byte_data is valid.
- framing_err  out  1  one-cycle strobe; stop bit sampled low.
- msg_status  out  8  status byte of the assembled message.
- msg_d1  out  7  first data byte; 0 if the message has none.
- msg_d2  out  7  second data byte; 0 if the message has none.
- msg_valid  out  1  one-cycle strobe; complete message on msg_*.
- rt_data  out  8  realtime byte, 0xF8-0xFF.
- rt_valid  out  1  one-cycle strobe for a realtime byte.
- sysex_active  out  1  high from 0xF0 until 0xF7 or any other status byte.
- orphan_cnt  out  8  count of data bytes dropped for lack of status; saturates at 255.
- activity  out  1  high for ACT_CYCLES after any byte_valid.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, running status cleared, UART state IDLE, parser data index 0. Reset mid-byte abandons the byte; no strobe is produced.
- Input sync: two-flop synchroniser on rx, reset value 1.
- DIV = CLK_HZ/BAUD (integer division); bit counter is $clog2(DIV) bits wide.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: falling edge on the synced rx goes to START and loads the counter with DIV/2-1.
  - START: on expiry, if rx is still low go to DATA with the counter at DIV-1; if rx is high it was a glitch, return to IDLE with no strobe.
  - DATA: sample every DIV cycles, 8 bits LSB first, then go to STOP.
  - STOP: sample after DIV. rx=1 gives byte_valid for 1 cycle with byte_data updated. rx=0 gives framing_err for 1 cycle; the byte is discarded and the parser is untouched.
  - Both cases return to IDLE. A new start edge is accepted the cycle after.
- Parser (acts on byte_valid; outputs registered, so msg_valid/rt_valid come exactly 1 cycle after the byte_valid of the completing byte):
  - 0xF8-0xFF: rt_valid with rt_data. Running status, data index and sysex_active are unchanged. Allowed between any two bytes.
  - 0x80-0xEF: latch as running status, clear data index, sysex_active=0. Expected data length: 2 for 8x/9x/Ax/Bx/Ex, 1 for Cx/Dx.
  - 0xF0: sysex_active=1, running status cleared.
  - 0xF7: sysex_active=0, running status cleared, no message.
  - System common (sysex_active=0, running status cleared on entry):
    - 0xF1 and 0xF3: length 1.
    - 0xF2: length 2.
    - 0xF6: length 0, so msg_valid on the next cycle with d1=d2=0.
    - 0xF4 and 0xF5: ignored.
  - Data byte 0x00-0x7F:
    - If sysex_active: ignored.
    - If no pending status: orphan_cnt +1 (saturating) and dropped.
    - Otherwise store to d1, then d2. When the index reaches the expected length, msg_valid fires.
    - After msg_valid, channel statuses keep running status (index back to 0); system common statuses clear it.
  - msg_* outputs hold their last value until the next message.
- activity: counter reloads to ACT_CYCLES-1 on byte_valid and is high while non-zero. A retrigger while high extends the pulse.

Decomposition:
- Shared package midi_pkg holds:
  - MIDI status constants: ST_SYSEX=F0, ST_EOX=F7, RT_MIN=F8.
  - Function midi_len(status) returning 0-2.
  - Enum uart_state_t.
- One sub-module, midi_uart_rx: synchroniser plus UART FSM, exposing byte_data/byte_valid/framing_err.
- The parser and activity stretcher stay in the top module.

Test Plan (CLK_HZ=1600000, BAUD=31250, so DIV=51; ACT_CYCLES=100):
- Bytes 0x90, 0x3C, 0x64: exactly one msg_valid with status=90, d1=3C, d2=64, one cycle after the third byte_valid. activity is high.
- Continue with 0x3E, 0x00 (running status): second msg_valid with 90/3E/00. orphan_cnt stays 0.
- 0x90, 0xF8, 0x3C, 0xFE, 0x64: rt_valid with F8, then FE. One msg_valid 90/3C/64. No extra messages.
- Byte 0x55 with stop bit forced low: framing_err pulses once, no byte_valid, parser state unchanged. Then 0xC5, 0x07 gives msg_valid C5/07/00.
- Reset with no running status, then 0x40, then F0 41 10 F7, then 0x12: orphan_cnt=2. sysex_active is high from F0 to F7. No msg_valid.
- Assert reset in the middle of the DATA state, then release: no strobes. Then a 0.5-bit low glitch: no byte_valid. A subsequent 0xF6 gives msg_valid F6/00/00.
